fp_mul: RTL and testbench



---
 rtl/fp_pkg.sv | 22 ++
 rtl/fp_unpack.sv | 26 ++
 rtl/fp_mul.sv | 94 +++++++++
 tb/tb_fp_mul.sv | 129 ++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared binary32 field widths, constants and the unpacked operand type (used by fp_mul and fpadd).
package fp_pkg;

    localparam int unsigned EXP_W   = 8;
    localparam int unsigned FRAC_W  = 23;
    localparam int unsigned WORD_W  = 1 + EXP_W + FRAC_W;
    localparam int unsigned BIAS    = 127;
    localparam int unsigned EXP_MAX = 255;

    localparam logic [WORD_W-1:0] CANON_NAN = 32'h7FC0_0000;
    localparam logic [WORD_W-1:0] POS_INF   = 32'h7F80_0000;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
        logic              is_zero;
        logic              is_inf;
        logic              is_nan;
    } fp_unpacked_t;

endpackage

// File: rtl/fp_unpack.sv
// Combinational binary32 decoder; subnormals are reported as zero (denormals-are-zero).
module fp_unpack
    import fp_pkg::*;
(
    input  logic [WORD_W-1:0] word,
    output fp_unpacked_t      op_c
);

    logic exp_all_ones;
    logic frac_nonzero;

    // Split fields and classify the operand.
    always_comb begin
        exp_all_ones = (word[WORD_W-2 -: EXP_W] == EXP_W'(EXP_MAX));
        frac_nonzero = |word[FRAC_W-1:0];

        op_c         = '0;
        op_c.sign    = word[WORD_W-1];
        op_c.exp     = word[WORD_W-2 -: EXP_W];
        op_c.frac    = word[FRAC_W-1:0];
        op_c.is_zero = (word[WORD_W-2 -: EXP_W] == '0);
        op_c.is_inf  = exp_all_ones && !frac_nonzero;
        op_c.is_nan  = exp_all_ones && frac_nonzero;
    end

endmodule

// File: rtl/fp_mul.sv
// Binary32 multiplier, RNE rounding, DAZ/FTZ, one registered output stage.
module fp_mul
    import fp_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic [WORD_W-1:0] rs1,
    input  logic [WORD_W-1:0] rs2,
    output logic [WORD_W-1:0] out
);

    localparam int unsigned SIG_W  = FRAC_W + 1;
    localparam int unsigned PROD_W = 2 * SIG_W;
    localparam int unsigned EXPC_W = 10;

    fp_unpacked_t a_c;
    fp_unpacked_t b_c;

    logic                     sign;
    logic [PROD_W-1:0]        prod;
    logic signed [EXPC_W-1:0] exp_sum;
    logic signed [EXPC_W-1:0] exp_norm;
    logic signed [EXPC_W-1:0] exp_rnd;
    logic [FRAC_W-1:0]        mant;
    logic                     guard_bit;
    logic                     round_bit;
    logic                     sticky_bit;
    logic                     round_up;
    logic [SIG_W-1:0]         mant_rnd;
    logic [WORD_W-1:0]        result_c;

    fp_unpack u_unpack_a (
        .word (rs1),
        .op_c (a_c)
    );

    fp_unpack u_unpack_b (
        .word (rs2),
        .op_c (b_c)
    );

    // Significand product, normalization, RNE rounding and special-case selection.
    always_comb begin
        sign     = rs1[WORD_W-1] ^ rs2[WORD_W-1];
        prod     = PROD_W'({1'b1, a_c.frac}) * PROD_W'({1'b1, b_c.frac});
        exp_sum  = EXPC_W'({2'b00, a_c.exp}) + EXPC_W'({2'b00, b_c.exp}) - EXPC_W'(BIAS);

        // Product lies in [1,4); a set top bit means one extra position of normalization.
        if (prod[PROD_W-1]) begin
            mant       = prod[PROD_W-2 -: FRAC_W];
            guard_bit  = prod[FRAC_W];
            round_bit  = prod[FRAC_W-1];
            sticky_bit = |prod[FRAC_W-2:0];
            exp_norm   = exp_sum + EXPC_W'(1);
        end else begin
            mant       = prod[PROD_W-3 -: FRAC_W];
            guard_bit  = prod[FRAC_W-1];
            round_bit  = prod[FRAC_W-2];
            sticky_bit = |prod[FRAC_W-3:0];
            exp_norm   = exp_sum;
        end

        round_up = guard_bit && (round_bit || sticky_bit || mant[0]);
        mant_rnd = SIG_W'({1'b0, mant}) + SIG_W'(round_up);
        // Carry-out leaves the fraction all-zero; only the exponent moves.
        exp_rnd  = exp_norm + EXPC_W'(mant_rnd[SIG_W-1]);

        if (a_c.is_nan || b_c.is_nan) begin
            result_c = CANON_NAN;
        end else if ((a_c.is_inf && b_c.is_zero) || (a_c.is_zero && b_c.is_inf)) begin
            result_c = CANON_NAN;
        end else if (a_c.is_inf || b_c.is_inf) begin
            result_c = {sign, POS_INF[WORD_W-2:0]};
        end else if (a_c.is_zero || b_c.is_zero) begin
            result_c = {sign, (WORD_W-1)'(0)};
        end else if (exp_rnd >= $signed(EXPC_W'(EXP_MAX))) begin
            result_c = {sign, POS_INF[WORD_W-2:0]};
        end else if (exp_rnd <= $signed(EXPC_W'(0))) begin
            result_c = {sign, (WORD_W-1)'(0)};
        end else begin
            result_c = {sign, exp_rnd[EXP_W-1:0], mant_rnd[FRAC_W-1:0]};
        end
    end

    // Output register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            out <= '0;
        end else begin
            out <= result_c;
        end
    end

endmodule

// File: tb/tb_fp_mul.sv
// Scoreboard bench for fp_mul: driver queues expected results, monitor checks one cycle later.
module tb_fp_mul;

    logic        clk;
    logic        resetn;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] out;

    logic [31:0] exp_q[$];
    string       name_q[$];
    logic        vld_in;
    logic        done;

    int n_cmp;
    int n_bad;

    fp_mul dut (
        .clk    (clk),
        .resetn (resetn),
        .rs1    (rs1),
        .rs2    (rs2),
        .out    (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one operand pair for the next rising edge and queue its product.
    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expv, input string nm);
        @(negedge clk);
        resetn = 1'b1;
        rs1    = a;
        rs2    = b;
        vld_in = 1'b1;
        exp_q.push_back(expv);
        name_q.push_back(nm);
    endtask

    // Hold reset for one edge with live-looking operands; expect zero.
    task automatic issue_reset(input logic [31:0] a, input logic [31:0] b, input string nm);
        @(negedge clk);
        resetn = 1'b0;
        rs1    = a;
        rs2    = b;
        vld_in = 1'b1;
        exp_q.push_back(32'h0000_0000);
        name_q.push_back(nm);
    endtask

    // Monitor: every edge that consumed a tracked input is checked 1 time unit later.
    always @(posedge clk) begin
        logic        v;
        logic [31:0] e;
        string       nm;
        v = vld_in;
        #1;
        if (v) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL scoreboard_underflow: out=%h, no expected value queued", out);
            end else begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if (out !== e) begin
                    n_bad++;
                    $display("FAIL %s: got %h expected %h", nm, out, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        done   = 1'b0;
        vld_in = 1'b0;
        resetn = 1'b0;
        rs1    = 32'h4000_0000;
        rs2    = 32'h4040_0000;

        issue_reset(32'h4000_0000, 32'h4040_0000, "reset_0");
        issue_reset(32'h7F80_0000, 32'h0000_0000, "reset_1");

        // Back-to-back stream, no bubbles between vectors.
        issue(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, "two_x_three");
        issue(32'hBFC0_0000, 32'h4000_0000, 32'hC040_0000, "neg_1p5_x_two");
        issue(32'h3FC0_0000, 32'h3F80_0001, 32'h3FC0_0002, "rne_tie_odd");
        issue(32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002, "rne_below_half");
        issue(32'h3FFF_FFFF, 32'h3F80_0001, 32'h4000_0000, "round_carry");
        issue(32'hC000_0000, 32'hC000_0000, 32'h4080_0000, "neg_x_neg");
        issue(32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, "inf_x_zero");
        issue(32'h7F80_0000, 32'hC000_0000, 32'hFF80_0000, "inf_x_neg_two");
        issue(32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, "nan_x_one");
        issue(32'h8000_0000, 32'h3F80_0000, 32'h8000_0000, "negzero_x_one");
        issue(32'h7F7F_FFFF, 32'h4000_0000, 32'h7F80_0000, "overflow");
        issue(32'h0080_0000, 32'h3F00_0000, 32'h0000_0000, "underflow");
        issue(32'h0040_0000, 32'h4000_0000, 32'h0000_0000, "subnormal_daz");

        // Mid-stream reset discards the in-flight product, then streaming resumes.
        issue(32'h4040_0000, 32'h4040_0000, 32'h4110_0000, "pre_reset_three_sq");
        issue_reset(32'h4000_0000, 32'h4000_0000, "mid_reset");
        issue(32'h3F80_0000, 32'hC080_0000, 32'hC080_0000, "post_reset_one_x_neg4");
        issue(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, "post_reset_two_x_three");

        @(negedge clk);
        vld_in = 1'b0;
        repeat (3) @(negedge clk);

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d results never observed, expected 0", exp_q.size());
        end

        done = 1'b1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
